// File: rtl/eeprom_burst_ctrl.sv
// eeprom_burst_ctrl: turns a burst read/write command into a sequence of
// single-byte I2C master transactions, one address per transaction, with a
// fixed write-cycle wait after every programmed byte.
module eeprom_burst_ctrl #(
   parameter logic [7:0] DEV_ADDR   = 8'hA0,
   parameter int         ADDR_W     = 16,
   parameter int         LEN_W      = 8,
   parameter int         TWR_CYCLES = 250000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [7:0]        wr_data,
   output logic              wr_data_req,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              i2c_read_req,
   input  logic              i2c_read_req_ack,
   output logic              i2c_write_req,
   input  logic              i2c_write_req_ack,
   output logic [7:0]        i2c_slave_dev_addr,
   output logic [15:0]       i2c_slave_reg_addr,
   output logic [7:0]        i2c_write_data,
   input  logic [7:0]        i2c_read_data,
   input  logic              i2c_error,
   output logic              i2c_addr_2byte
);

   localparam int CNT_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TWR_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, RD_REQ, WR_FETCH, WR_REQ, WR_WAIT, DONE} state_t;

   // The command direction is held by the state register itself: a read
   // command only ever visits RD_REQ, a write only the WR_* states.
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rdreq_q, rdreq_d, wrreq_q, wrreq_d;
   logic [7:0]        rd_data_q, rd_data_d, wdata_q, wdata_d;
   logic              rd_valid_q, rd_valid_d, wr_data_req_q, wr_data_req_d;
   logic              done_q, done_d, err_q, err_d;
   logic              ready_q, ready_d, busy_q, busy_d;

   assign cmd_ready          = ready_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign error              = err_q;
   assign rd_data            = rd_data_q;
   assign rd_valid           = rd_valid_q;
   assign wr_data_req        = wr_data_req_q;
   assign i2c_read_req       = rdreq_q;
   assign i2c_write_req      = wrreq_q;
   assign i2c_write_data     = wdata_q;
   assign i2c_slave_reg_addr = 16'(addr_q);
   assign i2c_slave_dev_addr = DEV_ADDR;
   assign i2c_addr_2byte     = (ADDR_W == 16);

   // Next-state and next-output logic; strobes default low each cycle.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      rdreq_d       = rdreq_q;
      wrreq_d       = wrreq_q;
      rd_data_d     = rd_data_q;
      wdata_d       = wdata_q;
      err_d         = err_q;
      rd_valid_d    = 1'b0;
      wr_data_req_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               addr_d = cmd_addr;
               len_d  = cmd_len;
               err_d  = 1'b0;
               if (cmd_len == '0) begin
                  state_d = DONE;
               end else if (cmd_write) begin
                  state_d       = WR_FETCH;
                  wr_data_req_d = 1'b1;
               end else begin
                  state_d = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            // Req goes up one cycle after (re)entering; acks without req are ignored.
            if (!rdreq_q) begin
               rdreq_d = 1'b1;
            end else if (i2c_read_req_ack) begin
               rdreq_d = 1'b0;
               if (i2c_error) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  rd_data_d  = i2c_read_data;
                  rd_valid_d = 1'b1;
                  addr_d     = addr_q + ADDR_W'(1);
                  len_d      = len_q - LEN_W'(1);
                  if (len_q == LEN_W'(1)) state_d = DONE;
               end
            end
         end
         WR_FETCH: begin
            // wr_data_req is high during this cycle; the source's byte is taken now.
            wdata_d = wr_data;
            state_d = WR_REQ;
         end
         WR_REQ: begin
            if (!wrreq_q) begin
               wrreq_d = 1'b1;
            end else if (i2c_write_req_ack) begin
               wrreq_d = 1'b0;
               if (i2c_error) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  len_d   = len_q - LEN_W'(1);
                  cnt_d   = '0;
                  state_d = WR_WAIT;
               end
            end
         end
         WR_WAIT: begin
            // Stay exactly TWR_CYCLES cycles while the EEPROM programs the byte.
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (len_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d       = WR_FETCH;
                  wr_data_req_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      done_d  = (state_d == DONE);
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   // All state and outputs are registered; async reset drops the reqs at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         rdreq_q       <= 1'b0;
         wrreq_q       <= 1'b0;
         rd_data_q     <= 8'h00;
         wdata_q       <= 8'h00;
         err_q         <= 1'b0;
         rd_valid_q    <= 1'b0;
         wr_data_req_q <= 1'b0;
         done_q        <= 1'b0;
         ready_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         rdreq_q       <= rdreq_d;
         wrreq_q       <= wrreq_d;
         rd_data_q     <= rd_data_d;
         wdata_q       <= wdata_d;
         err_q         <= err_d;
         rd_valid_q    <= rd_valid_d;
         wr_data_req_q <= wr_data_req_d;
         done_q        <= done_d;
         ready_q       <= ready_d;
         busy_q        <= busy_d;
      end
   end

endmodule

// File: doc/eeprom_burst_ctrl.md
EEPROM_BURST_CTRL -- requirements
Module: eeprom_burst_ctrl

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'hA0, 8-bit I2C device address (R/W bit 0) driven to the master.
REQ-002 SHALL have parameter ADDR_W, default 16, EEPROM word-address width; legal values 8 or 16.
REQ-003 SHALL have parameter LEN_W, default 8, burst-length counter width.
REQ-004 SHALL have parameter TWR_CYCLES, default 250000, clk cycles of the post-write wait (5 ms at 50 MHz).
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: cmd_valid in 1, command request; cmd_ready out 1, idle and able to accept; cmd_write in 1, 1 = write and 0 = read; cmd_addr in ADDR_W, start address; cmd_len in LEN_W, byte count.
REQ-007 SHALL have ports: wr_data in 8, write byte from the source; wr_data_req out 1, one-cycle strobe consuming wr_data.
REQ-008 SHALL have ports: rd_data out 8, read byte; rd_valid out 1, one-cycle strobe.
REQ-009 SHALL have ports: busy out 1; done out 1, one-cycle end-of-command strobe; error out 1, sticky NACK flag.
REQ-010 SHALL have the following master-side ports:
- i2c_read_req out 1; i2c_read_req_ack in 1
- i2c_write_req out 1; i2c_write_req_ack in 1
- i2c_slave_dev_addr out 8; i2c_slave_reg_addr out 16, zero-extended from ADDR_W
- i2c_write_data out 8; i2c_read_data in 8
- i2c_error in 1, valid with ack
- i2c_addr_2byte out 1, constant (ADDR_W == 16)

Function
REQ-011 SHALL implement the states IDLE, RD_REQ, WR_FETCH, WR_REQ, WR_WAIT and DONE.
REQ-012 SHALL assert cmd_ready only in IDLE, and SHALL accept a command when cmd_valid && cmd_ready, latching addr, len and write into internal registers.
REQ-013 SHALL, for a command accepted with cmd_len == 0, go to DONE with no I2C traffic.
REQ-014 SHALL otherwise transition IDLE -> RD_REQ for a read and IDLE -> WR_FETCH for a write.
REQ-015 SHALL transfer one byte per master transaction, with the current address driven on i2c_slave_reg_addr.
REQ-016 SHALL raise the master req in the cycle after entering RD_REQ/WR_REQ, hold it until the matching ack is sampled high, drop it in the cycle following that ack, and never assert both reqs together.
REQ-017 SHALL, on i2c_read_req_ack with i2c_error=0, register i2c_read_data to rd_data and pulse rd_valid the next cycle.
REQ-018 SHALL, in WR_FETCH, pulse wr_data_req for one cycle, latch wr_data in that same cycle into i2c_write_data, and then go to WR_REQ.
REQ-019 SHALL, on i2c_write_req_ack with i2c_error=0, go to WR_WAIT and count TWR_CYCLES cycles before moving on.
REQ-020 SHALL, after each successful byte:
- increment the address modulo 2^ADDR_W (0xFFFF -> 0x0000 for ADDR_W=16; 0xFF -> 0x00 for 8)
- decrement the remaining count
- go to DONE when the count reaches 0, else return to RD_REQ or WR_FETCH
REQ-021 SHALL, on any ack with i2c_error=1, set error, skip WR_WAIT, and go to DONE, discarding the remaining bytes with no rd_valid and no further wr_data_req.
REQ-022 SHALL clear error when the next command is accepted.
REQ-023 SHALL, in DONE, pulse done for one cycle and return to IDLE; a new command SHALL NOT be accepted before the cycle after done.
REQ-024 SHALL hold busy = 1 in every state except IDLE.
REQ-025 SHALL ignore cmd_valid while busy, so commands are never queued.
REQ-026 SHALL ignore a master ack that arrives while no req is asserted.

Reset
REQ-027 SHALL, while rst_n = 0, force state IDLE and outputs cmd_ready=0, then 1 from the first clk after release.
REQ-028 SHALL, while rst_n = 0, drive busy, done, error, rd_valid, wr_data_req, i2c_read_req and i2c_write_req to 0, and rd_data and i2c_write_data to 8'h00.
REQ-029 SHALL, while rst_n = 0, drive i2c_slave_reg_addr to 0 and i2c_slave_dev_addr to DEV_ADDR.
REQ-030 SHALL, on reset asserted mid-transaction, drop both reqs immediately (asynchronously) and clear the WR_WAIT counter, with no done pulse.

Verification
REQ-031 SHALL cover a read: read addr 0x0010, len 3, model returns 0x11/0x22/0x33 -> three rd_valid strobes carrying those values; reg_addr sequence 0x10, 0x11, 0x12; one done; error=0.
REQ-032 SHALL cover a write with wait: write addr 0x0005, len 2, TWR_CYCLES=20 -> two wr_data_req strobes; the second write_req rises no earlier than 20 cycles after the first ack; done after the second wait.
REQ-033 SHALL cover wrap-around: read addr 0xFFFF, len 2 -> reg_addr sequence 0xFFFF, 0x0000.
REQ-034 SHALL cover a NACK: write len 4 with i2c_error=1 on the 2nd ack -> error=1, done, only 2 wr_data_req strobes, no WR_WAIT; a next command clears error.
REQ-035 SHALL cover reset: assert rst_n low while i2c_write_req=1 -> req drops within the same cycle, all outputs at reset values; after release, cmd_ready=1.
REQ-036 SHALL cover zero length and busy: cmd_len=0 -> done one cycle after acceptance with no req; cmd_valid held while busy -> no second acceptance until IDLE.
